// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide controller:
// op codes, datapath modes and FSM state encoding.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step
// on unsigned magnitudes held in a 2*WIDTH accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] trial_s;

  // Multiply: {hi,multiplier}; divide: {rem,dividend} with quotient shifted in at bit 0.
  always_comb begin
    sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    rem_sh_s = acc[2*WIDTH-1:WIDTH-1];
    trial_s  = rem_sh_s - {1'b0, operand};
    acc_next = acc;
    q_bit    = 1'b0;
    if (mode == MODE_MUL) begin
      acc_next = {sum_s, acc[WIDTH-1:1]};
      q_bit    = 1'b0;
    end else begin
      q_bit = ~trial_s[WIDTH];
      if (q_bit) begin
        acc_next = {trial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the iterative MIPS multiply/divide unit; owns HI/LO
// and raises busy/stall while a multi-cycle result is in flight.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             op_ready,
  input  logic             rd_hi_req,
  input  logic             rd_lo_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_t             state_r, state_next_s;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [WIDTH-1:0]   a_raw_r;
  logic               mode_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               dbz_pulse_r;

  logic               accept_s;
  logic               md_op_s;
  logic               signed_s;
  logic               div_s;
  logic [2*WIDTH-1:0] step_acc_s;
  logic               step_q_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  assign accept_s = op_valid && (state_r == ST_IDLE);
  assign md_op_s  = (op_code[2] == 1'b0);
  assign signed_s = ~op_code[0];
  assign div_s    = op_code[1];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode     (mode_r),
    .acc      (acc_r),
    .operand  (opnd_r),
    .acc_next (step_acc_s),
    .q_bit    (step_q_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && md_op_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FIX:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Sign fix-up of the unsigned result; divide by zero bypasses it entirely.
  always_comb begin
    prod_s   = neg_q_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
    fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    fix_lo_s = prod_s[WIDTH-1:0];
    if (mode_r == MODE_MUL) begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end else if (dbz_r) begin
      fix_hi_s = a_raw_r;
      fix_lo_s = {WIDTH{1'b1}};
    end else begin
      fix_lo_s = neg_q_r ? (~acc_r[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                         : acc_r[WIDTH-1:0];
      fix_hi_s = neg_r_r ? (~acc_r[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                         : acc_r[2*WIDTH-1:WIDTH];
    end
  end

  // Datapath, HI/LO and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= {CW{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      opnd_r      <= {WIDTH{1'b0}};
      a_raw_r     <= {WIDTH{1'b0}};
      mode_r      <= MODE_MUL;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      dbz_r       <= 1'b0;
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_pulse_r <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      dbz_pulse_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            case (op_code)
              OP_MTHI: hi_r <= operand_a;
              OP_MTLO: lo_r <= operand_a;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                mode_r  <= div_s ? MODE_DIV : MODE_MUL;
                a_raw_r <= operand_a;
                neg_q_r <= signed_s && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                neg_r_r <= signed_s && operand_a[WIDTH-1];
                dbz_r   <= div_s && (operand_b == {WIDTH{1'b0}});
                cnt_r   <= {CW{1'b0}};
                busy_r  <= 1'b1;
                if (div_s) begin
                  acc_r  <= {{WIDTH{1'b0}}, magnitude(operand_a, signed_s)};
                  opnd_r <= magnitude(operand_b, signed_s);
                end else begin
                  acc_r  <= {{WIDTH{1'b0}}, magnitude(operand_b, signed_s)};
                  opnd_r <= magnitude(operand_a, signed_s);
                end
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          acc_r <= step_acc_s | {{(2*WIDTH-1){1'b0}}, step_q_s};
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        ST_FIX: begin
          hi_r        <= fix_hi_s;
          lo_r        <= fix_lo_s;
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
          dbz_pulse_r <= dbz_r;
          cnt_r       <= {CW{1'b0}};
        end
        default: ;
      endcase
    end
  end

  assign op_ready    = (state_r == ST_IDLE);
  assign hi          = hi_r;
  assign lo          = lo_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_pulse_r;
  assign stall       = (rd_hi_req | rd_lo_req) & busy_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios plus randomized ops
// compared against an arithmetic reference model of HI/LO.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        op_ready;
  logic        rd_hi_req;
  logic        rd_lo_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .op_ready    (op_ready),
    .rd_hi_req   (rd_hi_req),
    .rd_lo_req   (rd_lo_req),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
  // the remainder follows the dividend sign, matching MIPS semantics.
  task automatic ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    rdz = 1'b0;
    rh = exp_hi;
    rl = exp_lo;
    case (op)
      3'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = {32'h0, a} * {32'h0, b}; rh = p[63:32]; rl = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'h0) begin
          rh = a; rl = 32'hFFFF_FFFF; rdz = 1'b1;
        end else begin
          if (op == 3'd3) begin
            sa = {32'h0, a};
            sb = {32'h0, b};
          end
          q = sa / sb;
          r = sa % sb;
          rl = q[31:0];
          rh = r[31:0];
        end
      end
      3'd4: rh = a;
      3'd5: rl = a;
      default: ;
    endcase
  endtask

  // Drive one op for a single accept edge; returns at the negedge after it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op_code = op; operand_a = a; operand_b = b;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Count edges after the accept edge until done; n is the done edge index.
  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; op_code = 3'd0; operand_a = 32'h0; operand_b = 32'h0;
    rd_hi_req = 1'b0; rd_lo_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo hi=%h lo=%h want 0", hi, lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_status busy=%b done=%b dbz=%b want 0", busy, done, div_by_zero); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", op_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    int n, bc;
    issue(3'd3, 32'd100, 32'd7);
    wait_done(n, bc);
    checks++; if (n !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", n); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL divu_busy_cycles got %0d want 33", bc); end
    checks++; if (hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL divu_100_7 hi=%h lo=%h want 2/e", hi, lo); end
    exp_hi = 32'd2; exp_lo = 32'd14;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width done=%b want 0", done); end
  endtask

  task automatic test_signed_cases();
    int n, bc;
    issue(3'd2, -32'sd7, 32'sd2);
    wait_done(n, bc);
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2 hi=%h lo=%h want ffffffff/fffffffd", hi, lo); end
    issue(3'd2, 32'sd7, -32'sd2);
    wait_done(n, bc);
    checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2 hi=%h lo=%h want 1/fffffffd", hi, lo); end
    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    wait_done(n, bc);
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_m1_2 hi=%h lo=%h want ffffffff/fffffffe", hi, lo); end
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_done(n, bc);
    checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_ffffffff_2 hi=%h lo=%h want 1/fffffffe", hi, lo); end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, bc);
    checks++; if (hi !== 32'h0 || lo !== 32'h8000_0000 || div_by_zero !== 1'b0) begin errors++; $display("FAIL div_overflow hi=%h lo=%h dbz=%b want 0/80000000/0", hi, lo, div_by_zero); end
    exp_hi = hi; exp_lo = lo;
  endtask

  task automatic test_div_zero();
    int n, bc;
    issue(3'd3, 32'd5, 32'd0);
    wait_done(n, bc);
    checks++; if (n !== 33) begin errors++; $display("FAIL dbz_latency got %0d want 33", n); end
    checks++; if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_result hi=%h lo=%h want 5/ffffffff", hi, lo); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_pulse got %b want 1", div_by_zero); end
    @(negedge clk);
    checks++; if (div_by_zero !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL dbz_pulse_end dbz=%b done=%b want 0/0", div_by_zero, done); end
    exp_hi = 32'd5; exp_lo = 32'hFFFF_FFFF;
  endtask

  task automatic test_move_ops();
    logic [31:0] v;
    v = $urandom;
    issue(3'd4, v, 32'h0);
    checks++; if (hi !== v || busy !== 1'b0) begin errors++; $display("FAIL mthi hi=%h busy=%b want %h/0", hi, busy, v); end
    exp_hi = v;
    v = $urandom;
    issue(3'd5, v, 32'h0);
    checks++; if (lo !== v || hi !== exp_hi || busy !== 1'b0) begin errors++; $display("FAIL mtlo lo=%h hi=%h busy=%b want %h/%h/0", lo, hi, busy, v, exp_hi); end
    exp_lo = v;
    issue(3'd6, $urandom, $urandom);
    @(negedge clk);
    checks++; if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0) begin errors++; $display("FAIL op110_ignored hi=%h lo=%h busy=%b want %h/%h/0", hi, lo, busy, exp_hi, exp_lo); end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int n, bc;
    logic [2:0] op;
    logic [31:0] a, b, rh, rl;
    logic rdz;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 6));
      a = pick();
      b = pick();
      ref_md(op, a, b, rh, rl, rdz);
      issue(op, a, b);
      if (op <= 3'd3) begin
        wait_done(n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL rand_latency op=%0d got %0d want 33", op, n); end
        checks++; if (div_by_zero !== rdz) begin errors++; $display("FAIL rand_dbz op=%0d a=%h b=%h got %b want %b", op, a, b, div_by_zero, rdz); end
      end
      checks++; if (hi !== rh || lo !== rl) begin errors++; $display("FAIL rand_result op=%0d a=%h b=%h hi=%h lo=%h want %h/%h", op, a, b, hi, lo, rh, rl); end
      exp_hi = rh; exp_lo = rl;
    end
  endtask

  task automatic test_stall_back_to_back();
    int n, bc, stall_bad;
    logic [31:0] rh, rl, dh, dl;
    logic rdz;
    rd_hi_req = 1'b1;
    ref_md(3'd0, 32'd123457, -32'sd55, rh, rl, rdz);
    issue(3'd0, 32'd123457, -32'sd55);
    n = 0; stall_bad = 0;
    while (!done && n < 40) begin
      if (busy && !stall) stall_bad++;
      if (n == 10) begin
        op_valid = 1'b1; op_code = 3'd3; operand_a = 32'd1000; operand_b = 32'd3;
      end
      @(negedge clk);
      n++;
    end
    checks++; if (stall_bad !== 0 || n !== 33) begin errors++; $display("FAIL stall_busy bad=%0d n=%0d want 0/33", stall_bad, n); end
    checks++; if (stall !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL stall_done_cycle stall=%b ready=%b want 0/1", stall, op_ready); end
    checks++; if (hi !== rh || lo !== rl) begin errors++; $display("FAIL mult_ignores_divu hi=%h lo=%h want %h/%h", hi, lo, rh, rl); end
    exp_hi = rh; exp_lo = rl;
    ref_md(3'd3, 32'd1000, 32'd3, dh, dl, rdz);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    checks++; if (busy !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b stall=%b want 1/1", busy, stall); end
    wait_done(n, bc);
    checks++; if (n !== 33 || hi !== dh || lo !== dl) begin errors++; $display("FAIL b2b_divu n=%0d hi=%h lo=%h want 33/%h/%h", n, hi, lo, dh, dl); end
    exp_hi = dh; exp_lo = dl;
    rd_hi_req = 1'b0;
  endtask

  task automatic test_reset_midrun();
    issue(3'd0, 32'h0123_4567, 32'h89);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL async_reset hi=%h lo=%h busy=%b ready=%b want 0/0/0/1", hi, lo, busy, op_ready); end
    @(negedge clk);
    rst = 1'b0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    @(negedge clk);
    issue(3'd4, 32'h1234, 32'h0);
    checks++; if (hi !== 32'h1234 || busy !== 1'b0) begin errors++; $display("FAIL mthi_after_reset hi=%h busy=%b want 1234/0", hi, busy); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || lo !== 32'h0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_mthi busy=%b lo=%h done=%b want 0/0/0", busy, lo, done); end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed_cases();
    test_div_zero();
    test_move_ops();
    test_random();
    test_stall_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
